fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage and IF/ID pipeline register: the consumer of the Hazard unit's stallIF/stallD outputs.
//  Owns the PC and issues one-outstanding-request fetches to instruction memory.
//  Buffers a returned word while decode is stalled, and flushes on branch/jump redirect.
//  Feeds instrD/pcD to decode, where Drs/Drt are extracted for the Hazard unit.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded by reset
//  NOP_INSTR 32'h0000_0000  word placed in instrD on bubble/flush (sll $0,$0,0)
//  CNT_W     16             stall counter width (only with FETCH_PERF_CNT_EN)
// PORTS
//  clk          in  1   rising-edge clock
//  rst          in  1   asynchronous reset, active-high
//  stallIF      in  1   Signal; ENABLE = do not advance PC / issue new request
//  stallD       in  1   Signal; ENABLE = hold IF/ID register
//  redirect     in  1   Signal; ENABLE = taken branch/jump resolved in D
//  redirect_pc  in  32  target PC, valid when redirect=ENABLE
//  imem_req     out 1   fetch request valid
//  imem_addr    out 32  fetch address (word aligned, [1:0]=0)
//  imem_ready   in  1   request accepted when imem_req & imem_ready
//  imem_valid   in  1   response valid, >=1 cycle after acceptance, in order
//  imem_rdata   in  32  instruction word, valid with imem_valid
//  instrD       out 32  IF/ID instruction
//  pcD          out 32  IF/ID PC of instrD
//  validD       out 1   IF/ID holds a real instruction
//  stall_cnt    out CNT_W  decode-stall cycles (only with FETCH_PERF_CNT_EN)
// BEHAVIOUR
//  Reset: pc=RESET_PC; state=S_REQ; buffer empty; kill=0.
//  Reset outputs: imem_req=0, instrD=NOP_INSTR, pcD=RESET_PC, validD=0, stall_cnt=0.
//  imem_req is registered and goes high on the first clock after rst deasserts.
//  FSM:
//   S_REQ:  imem_req=1, imem_addr=pc. On accept -> S_WAIT; pc<=pc+4 unless stallIF.
//           If stallIF is asserted in S_REQ, drop imem_req; issue nothing.
//   S_WAIT: await imem_valid.
//           If the word can be consumed (IF/ID not stalled) -> S_REQ.
//           Otherwise -> S_FULL; the word and its PC go into the 1-entry holding buffer.
//   S_FULL: imem_req=0. When stallD deasserts, the buffer loads IF/ID and empties -> S_REQ.
//  IF/ID update each cycle, in priority order:
//   1. redirect -> validD<=0, instrD<=NOP_INSTR; overrides stallD.
//   2. stallD -> hold all IF/ID outputs.
//   3. buffer full -> load from buffer.
//   4. imem_valid in S_WAIT and not killed -> load imem_rdata; pcD is the request PC.
//   5. Otherwise insert a bubble: validD<=0, instrD<=NOP_INSTR.
//  Redirect handling:
//   - pc<=redirect_pc and buffer is cleared, in the same cycle.
//   - If a request is outstanding (S_WAIT), kill<=1. The next response is discarded (kill<=0), then -> S_REQ.
//   - Redirect in S_REQ or S_FULL -> S_REQ immediately with the new PC.
//   - Redirect with simultaneous imem_valid in S_WAIT: the response is discarded, kill stays 0.
//   - Redirect overrides stallIF for the PC load.
//  PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0.
//  redirect_pc[1:0] is ignored (forced to 0).
//  Latency: request accepted at cycle N with a 1-cycle memory -> validD=1 at N+2.
//  Throughput: 1 instr per 2 cycles (one outstanding request).
//  rst asserted mid-transfer: immediate return to the reset state.
//   Any in-flight response is the memory's to abort; responses seen in the first cycle after reset are ignored.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//   - stall_cnt port exists; +1 each cycle stallD=ENABLE and validD=1.
//   - Saturates at all-ones; reset to 0.
//  FETCH_PERF_CNT_EN undefined: port and counter are absent; all other behaviour is identical.
// TESTING
//  1. Reset, 1-cycle memory returning 32'h2001_0005 @0 and 32'h2002_0007 @4:
//     validD=1 with pcD=0, then pcD=4, with instrD matching each word.
//  2. stallD high for 3 cycles while the word @8 returns:
//     - imem_req=0 during the stall; word held in the buffer.
//     - On release: pcD=8 next cycle, no word lost or duplicated.
//  3. Redirect to 32'h0000_0100 while the @C request is outstanding:
//     - @C response dropped.
//     - Next validD=1 has pcD=32'h100; validD=0 in the flush cycle.
//  4. redirect and stallD both asserted: IF/ID flushed (validD=0, instrD=NOP_INSTR) and pc=redirect_pc.
//  5. redirect_pc=32'hFFFF_FFFC: the fetch after it issues imem_addr=32'h0.
//     Assert rst mid-S_WAIT: all outputs reach reset values in the same cycle.
//  6. With FETCH_PERF_CNT_EN, CNT_W=4, 20 stall cycles with validD=1: stall_cnt saturates at 4'hF.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage plus the IF/ID pipeline register.
//
// The stage owns the PC and fetches with at most one request outstanding.
// A word that returns while decode is stalled waits in a one-entry holding
// buffer. A taken branch or jump that resolves in decode redirects the PC and
// flushes IF/ID. If a request is still in flight at that moment, its response
// is marked to be dropped when it arrives.
//
// Optional feature (compile-time macro FETCH_PERF_CNT_EN):
//   When defined, the CNT_W parameter and the stall_cnt output exist. The
//   counter is a saturating count of cycles in which decode is stalled while
//   holding a valid instruction. When undefined, both are absent and all
//   other behaviour is unchanged.
//
// Parameters
//   RESET_PC    PC loaded by reset
//   NOP_INSTR   word placed in instrD on a bubble or flush
//   CNT_W       stall counter width (FETCH_PERF_CNT_EN only)
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-high
//   stallIF      in   do not issue a new fetch request
//   stallD       in   hold the IF/ID register
//   redirect     in   taken branch/jump resolved in decode
//   redirect_pc  in   redirect target; bits [1:0] are ignored
//   imem_req     out  fetch request valid (low until the first clock after reset)
//   imem_addr    out  fetch address, word aligned
//   imem_ready   in   request accepted when imem_req & imem_ready
//   imem_valid   in   response valid, in order, >= 1 cycle after acceptance
//   imem_rdata   in   instruction word returned with imem_valid
//   instrD       out  IF/ID instruction
//   pcD          out  IF/ID PC of instrD
//   validD       out  IF/ID holds a real instruction
//   stall_cnt    out  decode-stall cycle count (FETCH_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
`ifdef FETCH_PERF_CNT_EN
    ,
    parameter int          CNT_W     = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallIF,
    input  logic             stallD,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic             imem_valid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instrD,
    output logic [31:0]      pcD,
    output logic             validD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    // S_FULL doubles as the "holding buffer occupied" flag.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_armed;       // low only during the first cycle after reset
    logic [31:0] r_pc;          // address of the next request
    logic [31:0] r_req_pc;      // address of the request in flight
    logic        r_kill;        // drop the next response (redirect while in flight)
    logic        w_kill_nxt;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc;
    logic [31:0] r_instrD;
    logic [31:0] r_pcD;
    logic        r_validD;

    logic        w_accept;
    logic        w_rsp;
    logic        w_rsp_live;
    logic        w_buf_load;
    logic [31:0] w_redirect_pc;
    logic        w_unused_pc_lsbs;

    // Targets are always word aligned. The low bits are dropped here.
    assign w_redirect_pc    = {redirect_pc[31:2], 2'b00};
    assign w_unused_pc_lsbs = ^redirect_pc[1:0];

    // A redirect masks the request. Otherwise a fetch of the stale PC could
    // be accepted in the same cycle the PC moves.
    assign imem_req  = r_armed && (r_state == S_REQ) && !stallIF && !redirect;
    assign imem_addr = r_pc;
    assign w_accept  = imem_req && imem_ready;

    // A response is only meaningful while a request is in flight. A killed
    // response, or one that meets a redirect, is discarded.
    assign w_rsp      = (r_state == S_WAIT) && imem_valid;
    assign w_rsp_live = w_rsp && !r_kill && !redirect;
    assign w_buf_load = w_rsp_live && stallD;

    // -----------------------------------------------------------------------
    // Next-state / kill logic
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_kill_nxt  = r_kill;
        unique case (r_state)
            S_REQ: begin
                if (w_accept) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_valid) begin
                    if (redirect || r_kill) begin
                        // Drop this response. A redirect in the same cycle
                        // means no later response needs killing.
                        w_state_nxt = S_REQ;
                        w_kill_nxt  = 1'b0;
                    end else if (stallD) begin
                        w_state_nxt = S_FULL;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end else if (redirect) begin
                    // The response is still coming. Wait for it and drop it.
                    w_kill_nxt = 1'b1;
                end
            end
            S_FULL: begin
                if (redirect || !stallD) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
                w_kill_nxt  = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control state, PC and request tracking
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments only. Every register
    // then samples pre-edge values, whatever order the blocks run in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_REQ;
            r_armed  <= 1'b0;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
            r_kill   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_armed <= 1'b1;
            r_kill  <= w_kill_nxt;
            if (w_accept) begin
                r_req_pc <= r_pc;
            end
            // Redirect wins over both stallIF and sequential advance.
            // The +4 wraps modulo 2^32.
            if (redirect) begin
                r_pc <= w_redirect_pc;
            end else if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Holding buffer payload
    // -----------------------------------------------------------------------
    // NOTE: the payload registers take no reset. Only S_FULL marks them as
    // occupied, and that flag is reset. Leaving data unreset keeps the reset
    // net off wide datapath flops.
    always_ff @(posedge clk) begin
        if (w_buf_load) begin
            r_buf_instr <= imem_rdata;
            r_buf_pc    <= r_req_pc;
        end
    end

    // -----------------------------------------------------------------------
    // IF/ID pipeline register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instrD <= NOP_INSTR;
            r_pcD    <= RESET_PC;
            r_validD <= 1'b0;
        end else if (redirect) begin
            // A flush overrides stallD. pcD keeps its last value.
            r_instrD <= NOP_INSTR;
            r_validD <= 1'b0;
        end else if (stallD) begin
            r_instrD <= r_instrD;
            r_pcD    <= r_pcD;
            r_validD <= r_validD;
        end else if (r_state == S_FULL) begin
            r_instrD <= r_buf_instr;
            r_pcD    <= r_buf_pc;
            r_validD <= 1'b1;
        end else if (w_rsp_live) begin
            r_instrD <= imem_rdata;
            r_pcD    <= r_req_pc;
            r_validD <= 1'b1;
        end else begin
            r_instrD <= NOP_INSTR;
            r_validD <= 1'b0;
        end
    end

    assign instrD = r_instrD;
    assign pcD    = r_pcD;
    assign validD = r_validD;

`ifdef FETCH_PERF_CNT_EN
    // -----------------------------------------------------------------------
    // Decode-stall counter: counts cycles a real instruction sits stalled in
    // decode, and saturates at all-ones.
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (stallD && r_validD && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage.
//
// A small instruction-memory model is always ready. It answers each accepted
// request after mem_lat cycles. The word at address 0 is 32'h2001_0005 and
// the word at address 4 is 32'h2002_0007. Every other address a returns
// 32'hC000_0000 | a.
//
// Inputs are changed 1 time unit after a rising edge. The handshake is
// sampled on the falling edge, when the design has settled.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallIF;
    logic        stallD;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic        validD;
`ifdef FETCH_PERF_CNT_EN
    logic [3:0]  stall_cnt;
`endif

    int          errors = 0;
    int          checks = 0;

    int          mem_lat;
    int          p_cnt;
    logic [31:0] p_addr;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .NOP_INSTR  (32'h0000_0000)
`ifdef FETCH_PERF_CNT_EN
        ,
        .CNT_W      (4)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stallIF     (stallIF),
        .stallD      (stallD),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .instrD      (instrD),
        .pcD         (pcD),
        .validD      (validD)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2001_0005;
            32'h0000_0004: return 32'h2002_0007;
            default:       return 32'hC000_0000 | a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock. The memory sees any accept on the falling edge and
    // drives its response just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (imem_req && imem_ready) begin
            p_addr = imem_addr;
            p_cnt  = mem_lat;
        end
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
        if (p_cnt > 0) begin
            p_cnt--;
            if (p_cnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem_word(p_addr);
            end
        end
    endtask

    initial begin
        rst         = 1'b0;
        stallIF     = 1'b0;
        stallD      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ready  = 1'b1;
        imem_valid  = 1'b0;
        imem_rdata  = 32'h0;
        mem_lat     = 1;
        p_cnt       = 0;
        p_addr      = 32'h0;

        // ---- reset values ----
        #2 rst = 1'b1;
        #2;
        check("rst_req",    {31'b0, imem_req}, 32'h0);
        check("rst_validD", {31'b0, validD},   32'h0);
        check("rst_instrD", instrD,            32'h0);
        check("rst_pcD",    pcD,               32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check("req_low_after_rst", {31'b0, imem_req}, 32'h0);

        // ---- 1: first two fetches with a 1-cycle memory ----
        tick();
        check("req_first_clk", {31'b0, imem_req}, 32'h1);
        check("addr_0",        imem_addr,         32'h0);
        tick();
        check("wait_validD",   {31'b0, validD},   32'h0);
        check("wait_req",      {31'b0, imem_req}, 32'h0);
        tick();
        check("w0_validD",     {31'b0, validD},   32'h1);
        check("w0_pcD",        pcD,               32'h0);
        check("w0_instrD",     instrD,            32'h2001_0005);
        check("addr_4",        imem_addr,         32'h4);
        tick();
        check("bubble_validD", {31'b0, validD},   32'h0);
        check("bubble_instrD", instrD,            32'h0);
        tick();
        check("w4_validD",     {31'b0, validD},   32'h1);
        check("w4_pcD",        pcD,               32'h4);
        check("w4_instrD",     instrD,            32'h2002_0007);
        check("addr_8",        imem_addr,         32'h8);

        // ---- 2: decode stalled while the word @8 returns ----
        tick();
        stallD = 1'b1;
        tick();
        check("stall1_req",    {31'b0, imem_req}, 32'h0);
        check("stall1_validD", {31'b0, validD},   32'h0);
        tick();
        check("stall2_req",    {31'b0, imem_req}, 32'h0);
        tick();
        check("stall3_req",    {31'b0, imem_req}, 32'h0);
        stallD = 1'b0;
        tick();
        check("w8_validD",     {31'b0, validD},   32'h1);
        check("w8_pcD",        pcD,               32'h8);
        check("w8_instrD",     instrD,            32'hC000_0008);
        check("after_buf_req", {31'b0, imem_req}, 32'h1);
        check("addr_C",        imem_addr,         32'hC);

        // ---- 3: redirect while the @C request is outstanding ----
        mem_lat = 2;
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        check("flush_validD",  {31'b0, validD},   32'h0);
        check("flush_instrD",  instrD,            32'h0);
        check("kill_req",      {31'b0, imem_req}, 32'h0);
        tick();
        check("killed_validD", {31'b0, validD},   32'h0);
        check("redir_req",     {31'b0, imem_req}, 32'h1);
        check("addr_100",      imem_addr,         32'h100);
        mem_lat = 1;
        tick();
        tick();
        check("w100_validD",   {31'b0, validD},   32'h1);
        check("w100_pcD",      pcD,               32'h100);
        check("w100_instrD",   instrD,            32'hC000_0100);

        // ---- 4: redirect and stallD together ----
        stallD      = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        #1 check("redir_masks_req", {31'b0, imem_req}, 32'h0);
        tick();
        check("rs_validD",     {31'b0, validD},   32'h0);
        check("rs_instrD",     instrD,            32'h0);
        redirect = 1'b0;
        stallD   = 1'b0;
        #1 check("addr_200",   imem_addr,         32'h200);

        // ---- 5: redirect meeting a response; misaligned target; PC wrap ----
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        check("drop_validD",   {31'b0, validD},   32'h0);
        #1 check("addr_top",   imem_addr,         32'hFFFF_FFFC);
        tick();
        tick();
        check("wtop_validD",   {31'b0, validD},   32'h1);
        check("wtop_pcD",      pcD,               32'hFFFF_FFFC);
        check("wtop_instrD",   instrD,            32'hFFFF_FFFC);
        check("addr_wrap",     imem_addr,         32'h0);

        // stallIF holds off the request
        stallIF = 1'b1;
        #1 check("stallIF_req",  {31'b0, imem_req}, 32'h0);
        tick();
        check("stallIF_req2",  {31'b0, imem_req}, 32'h0);
        stallIF = 1'b0;
        #1 check("stallIF_rel",  {31'b0, imem_req}, 32'h1);

        // reset asserted mid-S_WAIT, with a valid word in IF/ID
        tick();
        tick();
        check("pre_rst_pcD",   pcD,               32'h0);
        stallD  = 1'b1;
        mem_lat = 2;
        tick();
        check("held_validD",   {31'b0, validD},   32'h1);
        check("held_instrD",   instrD,            32'h2001_0005);
        #1 rst = 1'b1;
        p_cnt      = 0;
        imem_valid = 1'b0;
        #1;
        check("mid_rst_req",    {31'b0, imem_req}, 32'h0);
        check("mid_rst_validD", {31'b0, validD},   32'h0);
        check("mid_rst_instrD", instrD,            32'h0);
        check("mid_rst_pcD",    pcD,               32'h0);
        stallD  = 1'b0;
        mem_lat = 1;
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("restart_addr",  imem_addr,         32'h0);
        tick();
        tick();
        check("restart_validD", {31'b0, validD},  32'h1);
        check("restart_pcD",    pcD,              32'h0);

`ifdef FETCH_PERF_CNT_EN
        // ---- 6: saturating decode-stall counter ----
        stallD = 1'b1;
        check("cnt_zero", {28'b0, stall_cnt}, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        check("cnt_three", {28'b0, stall_cnt}, 32'h3);
        for (int i = 0; i < 17; i++) tick();
        check("cnt_sat", {28'b0, stall_cnt}, 32'hF);
        stallD = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
